controller: RTL

CONTROLLER -- requirements
Module: controller

---
 rtl/controller.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/controller.sv
// ---------------------------------------------------------------------------
// controller
//
// Multi-cycle instruction sequencer for a 16-bit datapath.  A small FSM
// walks each instruction through fetch, decode and register read, then
// either executes it (ALU, branch, jump) or performs the memory access
// (load, store).  Every strobe is decoded combinationally from the current
// state and the instruction fields, so an asynchronous reset returns all
// outputs to their defaults at once.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset (forces FETCH)
//   op_code        instruction bits 15-12
//   ext_op_code    instruction bits 7-4
//   cond_field     instruction bits 11-8 (branch/jump condition)
//   psr_flags      registered flags: bit0 C, bit2 L, bit5 F, bit6 Z, bit7 N
//   reg_write      register file write enable
//   alu_A_src      ALU A operand select (1 = register A, 0 = PC)
//   alu_B_src      ALU B operand select (1 = immediate, 0 = register B)
//   pc_en          PC update enable (exactly once per instruction)
//   loading        load in progress (memory addressed by register)
//   storing        store in progress (memory addressed by register)
//   instruction_en instruction register capture enable
//   mem_we         memory write enable
//   pc_src         next PC: 0 ALU result, 1 register B, 2 PC+1
//   reg_write_src  write-back data: 0 ALU, 1 memory, 2 PC+1
//   alu_cont       ALU operation code
//   state          current FSM state (debug)
// ---------------------------------------------------------------------------
module controller #(
   parameter int ALU_CONT_BITS    = 6,
   parameter int OP_CODE_BITS     = 4,
   parameter int EXT_OP_CODE_BITS = 4,
   parameter int REG_BITS         = 4,
   parameter int WIDTH            = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [OP_CODE_BITS-1:0]     op_code,
   input  logic [EXT_OP_CODE_BITS-1:0] ext_op_code,
   input  logic [REG_BITS-1:0]         cond_field,
   input  logic [WIDTH-1:0]            psr_flags,
   output logic                        reg_write,
   output logic                        alu_A_src,
   output logic                        alu_B_src,
   output logic                        pc_en,
   output logic                        loading,
   output logic                        storing,
   output logic                        instruction_en,
   output logic                        mem_we,
   output logic [1:0]                  pc_src,
   output logic [1:0]                  reg_write_src,
   output logic [ALU_CONT_BITS-1:0]    alu_cont,
   output logic [2:0]                  state
);

   typedef enum logic [2:0] {
      FETCH   = 3'd0,
      DECODE  = 3'd1,
      REGREAD = 3'd2,
      EXEC    = 3'd3,
      MEM_RD  = 3'd4,
      LOAD_WB = 3'd5,
      STORE   = 3'd6
   } state_t;

   localparam logic [OP_CODE_BITS-1:0] OP_RTYPE = OP_CODE_BITS'(4'b0000);
   localparam logic [OP_CODE_BITS-1:0] OP_ADDI  = OP_CODE_BITS'(4'b0101);
   localparam logic [OP_CODE_BITS-1:0] OP_SUBI  = OP_CODE_BITS'(4'b1001);
   localparam logic [OP_CODE_BITS-1:0] OP_ANDI  = OP_CODE_BITS'(4'b0001);
   localparam logic [OP_CODE_BITS-1:0] OP_ORI   = OP_CODE_BITS'(4'b0010);
   localparam logic [OP_CODE_BITS-1:0] OP_XORI  = OP_CODE_BITS'(4'b0011);
   localparam logic [OP_CODE_BITS-1:0] OP_MOVI  = OP_CODE_BITS'(4'b1101);
   localparam logic [OP_CODE_BITS-1:0] OP_CMPI  = OP_CODE_BITS'(4'b1011);
   localparam logic [OP_CODE_BITS-1:0] OP_BCOND = OP_CODE_BITS'(4'b1100);
   localparam logic [OP_CODE_BITS-1:0] OP_SPEC  = OP_CODE_BITS'(4'b0100);

   localparam logic [EXT_OP_CODE_BITS-1:0] EXT_ADD   = EXT_OP_CODE_BITS'(4'b0101);
   localparam logic [EXT_OP_CODE_BITS-1:0] EXT_SUB   = EXT_OP_CODE_BITS'(4'b1001);
   localparam logic [EXT_OP_CODE_BITS-1:0] EXT_AND   = EXT_OP_CODE_BITS'(4'b0001);
   localparam logic [EXT_OP_CODE_BITS-1:0] EXT_OR    = EXT_OP_CODE_BITS'(4'b0010);
   localparam logic [EXT_OP_CODE_BITS-1:0] EXT_XOR   = EXT_OP_CODE_BITS'(4'b0011);
   localparam logic [EXT_OP_CODE_BITS-1:0] EXT_MOV   = EXT_OP_CODE_BITS'(4'b1101);
   localparam logic [EXT_OP_CODE_BITS-1:0] EXT_CMP   = EXT_OP_CODE_BITS'(4'b1011);
   localparam logic [EXT_OP_CODE_BITS-1:0] EXT_LOAD  = EXT_OP_CODE_BITS'(4'b0000);
   localparam logic [EXT_OP_CODE_BITS-1:0] EXT_STOR  = EXT_OP_CODE_BITS'(4'b0100);
   localparam logic [EXT_OP_CODE_BITS-1:0] EXT_JAL   = EXT_OP_CODE_BITS'(4'b1000);
   localparam logic [EXT_OP_CODE_BITS-1:0] EXT_JCOND = EXT_OP_CODE_BITS'(4'b1100);

   localparam logic [REG_BITS-1:0] COND_EQ = REG_BITS'(4'b0000);
   localparam logic [REG_BITS-1:0] COND_NE = REG_BITS'(4'b0001);
   localparam logic [REG_BITS-1:0] COND_CS = REG_BITS'(4'b0010);
   localparam logic [REG_BITS-1:0] COND_CC = REG_BITS'(4'b0011);
   localparam logic [REG_BITS-1:0] COND_GT = REG_BITS'(4'b0110);
   localparam logic [REG_BITS-1:0] COND_LE = REG_BITS'(4'b0111);
   localparam logic [REG_BITS-1:0] COND_UC = REG_BITS'(4'b1110);

   state_t cur_state;
   logic   taken;
   logic   is_load;
   logic   is_stor;

   // Only C, Z and N feed the condition logic; L and F are carried for
   // other consumers of the flag register.
   logic unused_flags;
   assign unused_flags = ^psr_flags;

   assign is_load = (op_code == OP_SPEC) && (ext_op_code == EXT_LOAD);
   assign is_stor = (op_code == OP_SPEC) && (ext_op_code == EXT_STOR);
   assign state   = cur_state;

   // Sequencer.  Memory instructions branch off after register read; all
   // paths end by returning to FETCH in the cycle that pulses pc_en.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state <= FETCH;
      end else begin
         case (cur_state)
            FETCH:   cur_state <= DECODE;
            DECODE:  cur_state <= REGREAD;
            REGREAD: begin
               if (is_load)
                  cur_state <= MEM_RD;
               else if (is_stor)
                  cur_state <= STORE;
               else
                  cur_state <= EXEC;
            end
            EXEC:    cur_state <= FETCH;
            MEM_RD:  cur_state <= LOAD_WB;
            LOAD_WB: cur_state <= FETCH;
            STORE:   cur_state <= FETCH;
            default: cur_state <= FETCH;
         endcase
      end
   end

   // Condition evaluation shared by Bcond and Jcond.  Unlisted codes are
   // never taken.
   always_comb begin
      taken = 1'b0;
      case (cond_field)
         COND_EQ: taken = psr_flags[6];
         COND_NE: taken = ~psr_flags[6];
         COND_CS: taken = psr_flags[0];
         COND_CC: taken = ~psr_flags[0];
         COND_GT: taken = psr_flags[7];
         COND_LE: taken = ~psr_flags[7];
         COND_UC: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   // Output decode.  Defaults address memory by PC and select PC+1, so any
   // state or encoding not listed behaves as a plain PC advance.
   always_comb begin
      reg_write      = 1'b0;
      alu_A_src      = 1'b1;
      alu_B_src      = 1'b0;
      pc_en          = 1'b0;
      loading        = 1'b0;
      storing        = 1'b0;
      instruction_en = 1'b0;
      mem_we         = 1'b0;
      pc_src         = 2'd2;
      reg_write_src  = 2'd0;
      alu_cont       = '0;
      case (cur_state)
         DECODE: instruction_en = 1'b1;
         EXEC: begin
            pc_en = 1'b1;
            case (op_code)
               OP_RTYPE: begin
                  case (ext_op_code)
                     EXT_ADD, EXT_SUB, EXT_AND, EXT_OR, EXT_XOR, EXT_MOV: begin
                        alu_cont  = ALU_CONT_BITS'({2'b00, ext_op_code});
                        reg_write = 1'b1;
                     end
                     EXT_CMP: alu_cont = ALU_CONT_BITS'({2'b00, ext_op_code});
                     default: ;
                  endcase
               end
               OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI, OP_MOVI, OP_CMPI: begin
                  alu_B_src = 1'b1;
                  alu_cont  = ALU_CONT_BITS'({2'b01, op_code});
                  reg_write = (op_code != OP_CMPI);
               end
               OP_BCOND: begin
                  alu_A_src = 1'b0;
                  alu_B_src = 1'b1;
                  alu_cont  = ALU_CONT_BITS'(6'b000101);
                  pc_src    = taken ? 2'd0 : 2'd2;
               end
               OP_SPEC: begin
                  case (ext_op_code)
                     EXT_JAL: begin
                        reg_write     = 1'b1;
                        reg_write_src = 2'd2;
                        pc_src        = 2'd1;
                     end
                     EXT_JCOND: pc_src = taken ? 2'd1 : 2'd2;
                     default: ;
                  endcase
               end
               default: ;
            endcase
         end
         MEM_RD: loading = 1'b1;
         LOAD_WB: begin
            loading       = 1'b1;
            reg_write     = 1'b1;
            reg_write_src = 2'd1;
            pc_en         = 1'b1;
         end
         STORE: begin
            storing = 1'b1;
            mem_we  = 1'b1;
            pc_en   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
